uart_rx_cfg: RTL
================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the next-generation replacement for the fixed 8N1 receive path inside top_uart. It adds configurable data width, parity and stop bits, and 3-sample majority voting at mid-bit. It also detects break conditions and presents received words on a valid/ready handshake with overrun reporting. It sits between the rx pin and the receive FIFO; its data_valid/data_ready pair connects directly to the FIFO write side.

Parameters:
CLK_PER_BIT, 326, clock cycles per bit period; legal range ≥ 8. 326 gives about 153.4 kbaud at 50 MHz.
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial input; idle high
data_out  out  DATA_BITS  received word, LSB = first data bit
data_perr  out  1  parity error flag for data_out; valid while data_valid = 1
data_ferr  out  1  framing error flag for data_out; valid while data_valid = 1
data_valid  out  1  data_out/data_perr/data_ferr hold a word not yet accepted
data_ready  in  1  consumer accepts the word in a cycle where data_valid = 1 and data_ready = 1
rx_done_tick  out  1  1-cycle pulse when a frame is delivered
overrun_tick  out  1  1-cycle pulse when a completed frame is dropped
break_tick  out  1  1-cycle pulse on break detection

Behaviour:
- Input sync: rx passes through a 2-FF synchroniser, both FFs reset to 1. All logic below uses the synchronised rx_s. Pin-to-rx_s latency is 2 cycles.
- Bit timer: bit_cnt counts 0..CLK_PER_BIT-1 and is $clog2(CLK_PER_BIT) wide. Samples are taken at M-1, M and M+1, where M = CLK_PER_BIT/2 (integer division). The bit value is the majority of the 3 samples and is resolved at M+1.
- States: IDLE, START, DATA, PAR, STOP, BRK_WAIT.
- IDLE: bit_cnt = 0. On rx_s = 0 go to START with bit_cnt = 0.
- START: at the M+1 resolve, majority 1 is a false start; return to IDLE with no outputs. Majority 0 continues; at CLK_PER_BIT-1 go to DATA.
- DATA: shift DATA_BITS bits in LSB first. After the last bit, go to PAR if PARITY ≠ 0, else STOP.
- PAR: compute the error flag. Odd parity: error if XOR(data, parity bit) = 0. Even parity: error if XOR(data, parity bit) = 1.
- STOP: resolve each stop bit at M+1. Any stop sample resolving to 0 sets ferr. Frame completion happens at the M+1 resolve of the last stop bit, not at the end of the bit period. From there go to IDLE, or to BRK_WAIT on break.
- Break: all data bits = 0, parity bit (if present) = 0, and first stop bit = 0. On break, assert break_tick once. The word is not delivered, rx_done_tick stays 0, and overrun is not checked. In BRK_WAIT, return to IDLE on the first cycle rx_s = 1.
- Delivery, at frame completion (non-break):
  - If data_valid = 0, or data_valid = 1 and data_ready = 1 in the same cycle: load data_out/data_perr/data_ferr, set data_valid = 1, pulse rx_done_tick.
  - Else: drop the new word, keep the old word, pulse overrun_tick.
- Handshake: data_valid clears in a cycle where data_valid = 1 and data_ready = 1 (unless reloaded that cycle). Outputs stay stable while data_valid = 1 and data_ready = 0.
- Framing errors: the word is still delivered, with data_ferr = 1.
- Reset: state = IDLE, counters = 0, data_out = 0, data_perr = 0, data_ferr = 0, data_valid = 0, all ticks = 0. Reset mid-frame abandons the frame and produces no tick.
- Back-to-back frames: a start edge is accepted on the cycle after completion in IDLE; no idle gap is required.

Test Plan:
1. Defaults, 8N1 frames 0x55, 0xAA, 0x0F, 0xF0, each bit driven for 326 clk, data_ready = 1 → four rx_done_tick pulses; data_out matches each byte; data_perr = data_ferr = 0; no overrun_tick.
2. PARITY = 2, DATA_BITS = 7, CLK_PER_BIT = 16: send 0x35 with correct parity bit 0, then 0x35 with parity bit 1 → data_out = 0x35 both times; data_perr = 0, then 1.
3. STOP_BITS = 2: send 0xA5 with second stop bit = 0 → delivered with data_ferr = 1 and data_out = 0xA5. Then a 0 glitch lasting CLK_PER_BIT/4 on the idle line → false start; no tick; state returns to IDLE.
4. data_ready = 0: send 0x11 then 0x22 → one rx_done_tick, then one overrun_tick; data_out stays 0x11. Raising data_ready for 1 cycle clears data_valid.
5. Hold rx low for 20 bit periods, then release → exactly one break_tick; data_valid = 0; a following 0x3C frame is received correctly.
6. Assert reset at bit 4 of a 0xFF frame, then send 0x81 → no output from the aborted frame; 0x81 is received cleanly. Also check a single bit-period sample flipped at M only → majority vote still yields the correct byte.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with 3-sample majority voting,
// parity/framing checks, break detection and a valid/ready output stage.
module uart_rx_cfg #(
    parameter int unsigned CLK_PER_BIT = 326,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_perr,
    output logic                 data_ferr,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 rx_done_tick,
    output logic                 overrun_tick,
    output logic                 break_tick
);

    localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
    localparam int unsigned MID   = CLK_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_RES  = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_DLAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_SLAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_BRK_WAIT
    } state_t;

    logic                 rx_meta_q, rx_s_q;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 ovr_q, ovr_d;
    logic                 brk_tick_q, brk_tick_d;

    logic maj_c, at_res_c, cnt_last_c, par_xor_c, par_err_c;
    logic frame_ferr_c, brk_now_c;

    // Two-flop synchroniser for the asynchronous rx pin; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Majority vote of the two stored samples and the current one, plus parity check.
    always_comb begin
        maj_c      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
        at_res_c   = (bit_cnt_q == CNT_RES);
        cnt_last_c = (bit_cnt_q == CNT_LAST);
        par_xor_c  = (^shift_q) ^ par_bit_q;
        if (PARITY == 1) begin
            par_err_c = ~par_xor_c;
        end else if (PARITY == 2) begin
            par_err_c = par_xor_c;
        end else begin
            par_err_c = 1'b0;
        end
    end

    // Next-state, datapath and output-stage logic.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        bit_idx_d    = bit_idx_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        ferr_d       = ferr_q;
        brk_d        = brk_q;
        data_out_d   = data_out_q;
        perr_out_d   = perr_out_q;
        ferr_out_d   = ferr_out_q;
        valid_d      = valid_q;
        done_d       = 1'b0;
        ovr_d        = 1'b0;
        brk_tick_d   = 1'b0;
        frame_ferr_c = ferr_q;
        brk_now_c    = brk_q;

        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        if (state_q != S_IDLE && state_q != S_BRK_WAIT) begin
            bit_cnt_d = cnt_last_c ? '0 : bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_PRE) samp_d[0] = rx_s_q;
            if (bit_cnt_q == CNT_MID) samp_d[1] = rx_s_q;
        end

        case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                bit_idx_d = '0;
                ferr_d    = 1'b0;
                brk_d     = 1'b0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (at_res_c && maj_c) begin
                    state_d   = S_IDLE;
                    bit_cnt_d = '0;
                end else if (cnt_last_c) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (at_res_c) begin
                    shift_d = {maj_c, shift_q[DATA_BITS-1:1]};
                end
                if (cnt_last_c) begin
                    if (bit_idx_q == IDX_DLAST) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            S_PAR: begin
                if (at_res_c) begin
                    par_bit_d = maj_c;
                end
                if (cnt_last_c) begin
                    state_d   = S_STOP;
                    bit_idx_d = '0;
                end
            end
            S_STOP: begin
                if (at_res_c) begin
                    frame_ferr_c = ferr_q | ~maj_c;
                    ferr_d       = frame_ferr_c;
                    if (bit_idx_q == '0) begin
                        brk_now_c = (shift_q == '0) && ((PARITY == 0) || !par_bit_q) && !maj_c;
                    end
                    brk_d = brk_now_c;
                    // Frame completes at the resolve of the last stop bit.
                    if (bit_idx_q == IDX_SLAST) begin
                        bit_cnt_d = '0;
                        if (brk_now_c) begin
                            state_d    = S_BRK_WAIT;
                            brk_tick_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            if (!valid_q || data_ready) begin
                                data_out_d = shift_q;
                                perr_out_d = par_err_c;
                                ferr_out_d = frame_ferr_c;
                                valid_d    = 1'b1;
                                done_d     = 1'b1;
                            end else begin
                                ovr_d = 1'b1;
                            end
                        end
                    end
                end else if (cnt_last_c) begin
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                end
            end
            S_BRK_WAIT: begin
                bit_cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            data_out_q <= '0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            brk_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
            data_out_q <= data_out_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            brk_tick_q <= brk_tick_d;
        end
    end

    assign data_out     = data_out_q;
    assign data_perr    = perr_out_q;
    assign data_ferr    = ferr_out_q;
    assign data_valid   = valid_q;
    assign rx_done_tick = done_q;
    assign overrun_tick = ovr_q;
    assign break_tick   = brk_tick_q;

endmodule
